ctrl_sequencer: RTL and testbench

//  Multi-cycle fetch/decode/execute controller; the initiator side of the ALU interface.

---
 rtl/ctrl_sequencer_pkg.sv | 44 ++++
 rtl/ctrl_sequencer_decode.sv | 38 +++
 rtl/ctrl_sequencer.sv | 137 +++++++++++++
 tb/tb_ctrl_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_sequencer_pkg.sv
// Shared types for the fetch/decode/execute sequencer:
// opcodes, instruction classes, FSM states, decoded bundle.
package ctrl_sequencer_pkg;

   localparam int WORD_SIZE = 16;

   // ALU opcodes, forwarded unchanged on alu_opcode
   localparam logic [4:0] OP_NOP  = 5'd0;
   localparam logic [4:0] OP_ADD  = 5'd1;
   localparam logic [4:0] OP_SUB  = 5'd2;
   localparam logic [4:0] OP_COMP = 5'd3;
   // Sequencer-only opcodes
   localparam logic [4:0] OP_LDI  = 5'd8;
   localparam logic [4:0] OP_JMP  = 5'd9;
   localparam logic [4:0] OP_JEQ  = 5'd10;
   localparam logic [4:0] OP_JGT  = 5'd11;
   localparam logic [4:0] OP_HALT = 5'd31;

   typedef enum logic [2:0] {
      CL_NOP, CL_ALU, CL_LDI, CL_JMP,
      CL_JEQ, CL_JGT, CL_HALT
   } op_class_t;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
   } state_t;

   typedef struct packed {
      op_class_t  cls;
      logic [4:0] op;
      logic [2:0] rd;
      logic [2:0] rs1;
      logic [2:0] rs2;
      logic [7:0] imm8;
      logic       is_jump;
   } dec_t;

   function automatic logic [WORD_SIZE-1:0] sext8(
      input logic [7:0] v
   );
      return {{(WORD_SIZE-8){v[7]}}, v};
   endfunction

endpackage

// File: rtl/ctrl_sequencer_decode.sv
// Combinational instruction decoder.
// Ports: instr (16-bit word) -> dec (class, fields, is_jump).
module ctrl_sequencer_decode
   import ctrl_sequencer_pkg::*;
(
   input  logic [15:0] instr,
   output dec_t        dec
);

   logic [4:0] op;

   assign op = instr[15:11];

   always_comb begin
      dec      = '0;
      dec.op   = op;
      dec.rd   = instr[10:8];
      dec.rs1  = instr[7:5];
      dec.rs2  = instr[4:2];
      dec.imm8 = instr[7:0];
      dec.cls  = CL_NOP;
      unique case (1'b1)
         (op == OP_ADD),
         (op == OP_SUB),
         (op == OP_COMP): dec.cls = CL_ALU;
         (op == OP_LDI):  dec.cls = CL_LDI;
         (op == OP_JMP):  dec.cls = CL_JMP;
         (op == OP_JEQ):  dec.cls = CL_JEQ;
         (op == OP_JGT):  dec.cls = CL_JGT;
         (op == OP_HALT): dec.cls = CL_HALT;
         default:         dec.cls = CL_NOP;
      endcase
      dec.is_jump = (dec.cls == CL_JMP) ||
                    (dec.cls == CL_JEQ) ||
                    (dec.cls == CL_JGT);
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller.
// Ports: imem req/ack fetch, regfile read A/B + write,
// ALU operands/opcode out, result/flags in, halted, ovf_sticky.
module ctrl_sequencer
   import ctrl_sequencer_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 imem_req,
   output logic [PC_W-1:0]      imem_addr,
   input  logic                 imem_ack,
   input  logic [15:0]          imem_data,
   output logic [2:0]           rf_ra_addr,
   output logic [2:0]           rf_rb_addr,
   input  logic [WORD_SIZE-1:0] rf_ra_data,
   input  logic [WORD_SIZE-1:0] rf_rb_data,
   output logic                 rf_we,
   output logic [2:0]           rf_wa,
   output logic [WORD_SIZE-1:0] rf_wd,
   output logic [WORD_SIZE-1:0] alu_a,
   output logic [WORD_SIZE-1:0] alu_b,
   output logic [4:0]           alu_opcode,
   input  logic [WORD_SIZE-1:0] alu_c,
   input  logic                 alu_overflow,
   input  logic [1:0]           alu_comp_flag,
   output logic                 halted,
   output logic                 ovf_sticky
);

   state_t          state;
   logic [PC_W-1:0] pc;
   logic [15:0]     instr;
   logic            flag_eq;
   logic            flag_gt;
   logic            take;
   dec_t            d;

   ctrl_sequencer_decode u_dec (
      .instr (instr),
      .dec   (d)
   );

   assign imem_addr  = pc;
   assign rf_ra_addr = d.rs1;
   assign rf_rb_addr = d.rs2;

   assign take = (d.cls == CL_JMP) ||
                 ((d.cls == CL_JEQ) && flag_eq) ||
                 ((d.cls == CL_JGT) && flag_gt);

   // imem_req is registered: it rises on every transition
   // into FETCH, so only the first fetch after reset pays
   // one idle cycle while the request comes up.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_FETCH;
         pc         <= RESET_PC;
         instr      <= '0;
         flag_eq    <= 1'b0;
         flag_gt    <= 1'b0;
         imem_req   <= 1'b0;
         rf_we      <= 1'b0;
         rf_wa      <= '0;
         rf_wd      <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
         halted     <= 1'b0;
         ovf_sticky <= 1'b0;
      end else begin
         rf_we <= 1'b0;
         unique case (state)
            S_FETCH: begin
               if (imem_req && imem_ack) begin
                  instr    <= imem_data;
                  pc       <= pc + PC_W'(1);
                  imem_req <= 1'b0;
                  state    <= S_DECODE;
               end else begin
                  imem_req <= 1'b1;
               end
            end
            S_DECODE: begin
               unique case (1'b1)
                  d.is_jump: begin
                     if (take) pc <= PC_W'(d.imm8);
                     imem_req <= 1'b1;
                     state    <= S_FETCH;
                  end
                  (d.cls == CL_ALU): begin
                     alu_a      <= rf_ra_data;
                     alu_b      <= rf_rb_data;
                     alu_opcode <= d.op;
                     state      <= S_EXEC;
                  end
                  (d.cls == CL_LDI): state <= S_WB;
                  (d.cls == CL_HALT): begin
                     halted <= 1'b1;
                     state  <= S_HALT;
                  end
                  default: begin
                     imem_req <= 1'b1;
                     state    <= S_FETCH;
                  end
               endcase
            end
            S_EXEC: state <= S_WB;
            S_WB: begin
               if (d.cls == CL_LDI) begin
                  rf_we <= 1'b1;
                  rf_wa <= d.rd;
                  rf_wd <= sext8(d.imm8);
               end else if (d.op == OP_COMP) begin
                  flag_eq <= alu_comp_flag[0];
                  flag_gt <= alu_comp_flag[1];
               end else begin
                  rf_we      <= 1'b1;
                  rf_wa      <= d.rd;
                  rf_wd      <= alu_c;
                  ovf_sticky <= ovf_sticky | alu_overflow;
               end
               imem_req <= 1'b1;
               state    <= S_FETCH;
            end
            S_HALT: begin
               halted   <= 1'b1;
               imem_req <= 1'b0;
            end
            default: state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: models imem,
// regfile and ALU; table vectors plus hand-written sequences.
module tb_ctrl_sequencer;
   import ctrl_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [15:0] imem_data;
   logic [2:0]  rf_ra_addr, rf_rb_addr;
   logic [15:0] rf_ra_data, rf_rb_data;
   logic        rf_we;
   logic [2:0]  rf_wa;
   logic [15:0] rf_wd;
   logic [15:0] alu_a, alu_b, alu_c;
   logic [4:0]  alu_opcode;
   logic        alu_overflow;
   logic [1:0]  alu_comp_flag;
   logic        halted, ovf_sticky;

   int n_chk = 0;
   int n_err = 0;

   logic        ack_mode = 1'b1;
   logic        ack_man  = 1'b0;
   logic [15:0] imem    [256];
   logic [15:0] rf      [8];
   logic [15:0] init_rf [8];

   always #5 clk = ~clk;

   ctrl_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_data     (imem_data),
      .rf_ra_addr    (rf_ra_addr),
      .rf_rb_addr    (rf_rb_addr),
      .rf_ra_data    (rf_ra_data),
      .rf_rb_data    (rf_rb_data),
      .rf_we         (rf_we),
      .rf_wa         (rf_wa),
      .rf_wd         (rf_wd),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_opcode    (alu_opcode),
      .alu_c         (alu_c),
      .alu_overflow  (alu_overflow),
      .alu_comp_flag (alu_comp_flag),
      .halted        (halted),
      .ovf_sticky    (ovf_sticky)
   );

   assign imem_ack   = ack_mode ? imem_req : ack_man;
   assign imem_data  = imem[imem_addr];
   assign rf_ra_data = rf[rf_ra_addr];
   assign rf_rb_data = rf[rf_rb_addr];

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) rf[i] <= init_rf[i];
      end else if (rf_we) begin
         rf[rf_wa] <= rf_wd;
      end
   end

   always_comb begin
      alu_c = '0;
      alu_overflow = 1'b0;
      case (alu_opcode)
         OP_ADD: begin
            alu_c = alu_a + alu_b;
            alu_overflow = (alu_a[15] == alu_b[15]) &&
                           (alu_c[15] != alu_a[15]);
         end
         OP_SUB: begin
            alu_c = alu_a - alu_b;
            alu_overflow = (alu_a[15] != alu_b[15]) &&
                           (alu_c[15] != alu_a[15]);
         end
         default: ;
      endcase
      alu_comp_flag = {alu_a > alu_b, alu_a == alu_b};
   end

   function automatic logic [15:0] rr(
      input logic [4:0] op, input logic [2:0] rd,
      input logic [2:0] rs1, input logic [2:0] rs2);
      return {op, rd, rs1, rs2, 2'b00};
   endfunction

   function automatic logic [15:0] ri(
      input logic [4:0] op, input logic [2:0] rd,
      input logic [7:0] imm);
      return {op, rd, imm};
   endfunction

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
      end
   endtask

   task automatic clr_imem();
      for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_halt(input string name);
      for (int i = 0; i < 200; i++) begin
         if (halted) break;
         step();
      end
      chk({name, "_halt"}, halted, 1);
   endtask

   typedef struct {
      logic [15:0] instr;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] r3;
      logic        ovf;
      logic [7:0]  end_addr;
   } vec_t;

   vec_t vt [11];

   initial begin
      logic [15:0] wd5;
      int bad, fetches;

      for (int i = 0; i < 8; i++) init_rf[i] = 16'h0000;
      clr_imem();

      vt[0]  = '{rr(OP_ADD, 3, 1, 2), 16'd5, 16'd3, 16'd8, 1'b0, 8'h04};
      vt[1]  = '{rr(OP_ADD, 3, 1, 2), 16'h7FFF, 16'd1, 16'h8000, 1'b1, 8'h04};
      vt[2]  = '{rr(OP_SUB, 3, 1, 2), 16'd3, 16'd5, 16'hFFFE, 1'b0, 8'h04};
      vt[3]  = '{rr(OP_SUB, 3, 1, 2), 16'h8000, 16'd1, 16'h7FFF, 1'b1, 8'h04};
      vt[4]  = '{rr(OP_COMP, 3, 1, 2), 16'd4, 16'd4, 16'hDEAD, 1'b0, 8'h21};
      vt[5]  = '{rr(OP_COMP, 3, 1, 2), 16'd5, 16'd4, 16'hDEAD, 1'b0, 8'h31};
      vt[6]  = '{rr(OP_COMP, 3, 1, 2), 16'd3, 16'd4, 16'hDEAD, 1'b0, 8'h04};
      vt[7]  = '{ri(OP_LDI, 3, 8'h80), 16'd1, 16'd2, 16'hFF80, 1'b0, 8'h04};
      vt[8]  = '{ri(OP_LDI, 3, 8'h7F), 16'd1, 16'd2, 16'h007F, 1'b0, 8'h04};
      vt[9]  = '{rr(OP_NOP, 3, 1, 2), 16'd1, 16'd2, 16'hDEAD, 1'b0, 8'h04};
      vt[10] = '{rr(5'd20, 3, 1, 2), 16'd1, 16'd2, 16'hDEAD, 1'b0, 8'h04};

      // reset state
      @(posedge clk);
      #1;
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_we", rf_we, 0);
      chk("rst_halted", halted, 0);
      chk("rst_ovf", ovf_sticky, 0);
      chk("rst_opcode", alu_opcode, 0);

      // table: op r3,r1,r2; JEQ 0x20; JGT 0x30; HALT
      for (int v = 0; v < 11; v++) begin
         clr_imem();
         imem[0]     = vt[v].instr;
         imem[1]     = ri(OP_JEQ, 0, 8'h20);
         imem[2]     = ri(OP_JGT, 0, 8'h30);
         imem[3]     = rr(OP_HALT, 0, 0, 0);
         imem[8'h20] = rr(OP_HALT, 0, 0, 0);
         imem[8'h30] = rr(OP_HALT, 0, 0, 0);
         init_rf[1] = vt[v].a;
         init_rf[2] = vt[v].b;
         init_rf[3] = 16'hDEAD;
         do_reset();
         run_halt($sformatf("v%0d", v));
         chk($sformatf("v%0d_r3", v), rf[3], vt[v].r3);
         chk($sformatf("v%0d_ovf", v), ovf_sticky, vt[v].ovf);
         chk($sformatf("v%0d_pc", v), imem_addr, vt[v].end_addr);
         chk($sformatf("v%0d_req", v), imem_req, 0);
      end

      // write timing of LDI, LDI, ADD
      clr_imem();
      imem[0] = ri(OP_LDI, 1, 8'd5);
      imem[1] = ri(OP_LDI, 2, 8'd3);
      imem[2] = rr(OP_ADD, 3, 1, 2);
      imem[3] = rr(OP_HALT, 0, 0, 0);
      for (int i = 0; i < 8; i++) init_rf[i] = 16'h0000;
      do_reset();
      for (int c = 1; c <= 11; c++) begin
         step();
         if (c == 4) begin
            chk("t1_ldi_we", rf_we, 1);
            chk("t1_ldi_wa", rf_wa, 1);
            chk("t1_ldi_wd", rf_wd, 5);
         end
         if (c == 10) chk("t1_we_early", rf_we, 0);
         if (c == 11) begin
            chk("t1_add_we", rf_we, 1);
            chk("t1_add_wa", rf_wa, 3);
            chk("t1_add_wd", rf_wd, 8);
         end
      end

      // overflow sticky survives a clean ADD
      clr_imem();
      imem[0] = rr(OP_ADD, 3, 1, 2);
      imem[1] = rr(OP_ADD, 5, 4, 4);
      imem[2] = rr(OP_HALT, 0, 0, 0);
      init_rf[1] = 16'h7FFF;
      init_rf[2] = 16'h0001;
      init_rf[4] = 16'h0002;
      do_reset();
      run_halt("stk");
      chk("stk_r3", rf[3], 16'h8000);
      chk("stk_r5", rf[5], 16'h0004);
      chk("stk_ovf", ovf_sticky, 1);

      // delayed ack holds request
      clr_imem();
      ack_mode = 1'b0;
      ack_man  = 1'b0;
      do_reset();
      bad = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         if (!(imem_req === 1'b1 && imem_addr === 8'h00)) bad++;
      end
      chk("dly_stable", bad, 0);
      ack_man = 1'b1;
      step();
      ack_man = 1'b0;
      chk("dly_req_drop", imem_req, 0);
      chk("dly_pc", imem_addr, 8'h01);
      step();
      chk("dly_next_req", imem_req, 1);
      chk("dly_next_addr", imem_addr, 8'h01);
      ack_mode = 1'b1;

      // halt persists, reset recovers
      clr_imem();
      imem[0]     = ri(OP_JMP, 0, 8'h10);
      imem[8'h10] = rr(OP_HALT, 0, 0, 0);
      do_reset();
      run_halt("hlt");
      bad = 0;
      for (int c = 0; c < 25; c++) begin
         step();
         if (!(halted === 1'b1 && imem_req === 1'b0)) bad++;
      end
      chk("hlt_hold", bad, 0);
      chk("hlt_addr", imem_addr, 8'h11);
      do_reset();
      chk("hlt_rst_addr", imem_addr, 8'h00);
      chk("hlt_rst_halted", halted, 0);
      step();
      chk("hlt_rst_req", imem_req, 1);

      // busy loop on own address
      clr_imem();
      imem[0] = ri(OP_JMP, 0, 8'h00);
      do_reset();
      bad = 0;
      fetches = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         if (imem_req) begin
            fetches++;
            if (imem_addr !== 8'h00) bad++;
         end
      end
      chk("loop_addr", bad, 0);
      chk("loop_fetches", fetches, 6);
      chk("loop_halted", halted, 0);

      // reset during EXECUTE of ADD
      clr_imem();
      imem[0] = rr(OP_ADD, 3, 1, 2);
      init_rf[1] = 16'd1;
      init_rf[2] = 16'd2;
      init_rf[3] = 16'hDEAD;
      do_reset();
      step();
      step();
      step();
      chk("mx_opcode", alu_opcode, OP_ADD);
      chk("mx_a", alu_a, 1);
      rst_n = 1'b0;
      step();
      chk("mx_we", rf_we, 0);
      chk("mx_a0", alu_a, 0);
      chk("mx_b0", alu_b, 0);
      chk("mx_op0", alu_opcode, 0);
      chk("mx_wd0", rf_wd, 0);
      chk("mx_req0", imem_req, 0);
      rst_n = 1'b1;
      ack_mode = 1'b0;
      ack_man  = 1'b1;
      step();
      ack_man = 1'b0;
      chk("mx_stray_req", imem_req, 1);
      chk("mx_stray_addr", imem_addr, 8'h00);
      step();
      chk("mx_noadv_req", imem_req, 1);
      chk("mx_noadv_addr", imem_addr, 8'h00);
      chk("mx_r3", rf[3], 16'hDEAD);
      ack_mode = 1'b1;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
